dma_copy: RTL and testbench

Block-transfer initiator that drives the single-port data memory's write-enable, data-in, address and read-data interface on its own. It copies `Length` bytes from `SrcAddr` to `DstAddr`, or fills `Length` bytes at `DstAddr` with a constant. It sits beside the core and owns the memory port while `Busy` is high; the top-level mux hands the port back to the core when `Busy` is low.

---
 rtl/dma_copy_if.sv | 28 ++
 rtl/dma_copy.sv | 156 +++++++++++++++
 tb/tb_dma_copy.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_copy_if.sv
// rtl/dma_copy_if.sv - memory port bundle between the block-transfer initiator and the data memory
//   MemWriteEn : write enable toward memory
//   MemDataIn  : write data toward memory
//   MemAddress : address toward memory
//   MemDataOut : read data from memory
interface dma_copy_if #(
    parameter int W = 8,
    parameter int A = 8
);
    logic         MemWriteEn;
    logic [W-1:0] MemDataIn;
    logic [A-1:0] MemAddress;
    logic [W-1:0] MemDataOut;

    modport master (
        output MemWriteEn,
        output MemDataIn,
        output MemAddress,
        input  MemDataOut
    );

    modport slave (
        input  MemWriteEn,
        input  MemDataIn,
        input  MemAddress,
        output MemDataOut
    );
endinterface

// File: rtl/dma_copy.sv
// rtl/dma_copy.sv - block copy / fill engine that owns the memory port while Busy
//   Clk, Reset        : clock, synchronous active-high reset
//   Start, Mode       : request (sampled in IDLE only), 0 = copy, 1 = fill
//   SrcAddr, DstAddr  : base addresses, latched on Start
//   Length, FillValue : word count and fill word, latched on Start
//   Busy, Done        : port ownership, one-cycle completion pulse
//   mem               : memory port (write enable, write data, address, read data)
module dma_copy #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Mode,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A-1:0] Length,
    input  logic [W-1:0] FillValue,
    output logic         Busy,
    output logic         Done,
    dma_copy_if.master   mem
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [A-1:0] ONE = {{(A-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic         mode_q, mode_d;
    logic [A-1:0] src_q, src_d;
    logic [A-1:0] dst_q, dst_d;
    logic [A-1:0] len_q, len_d;
    logic [W-1:0] fill_q, fill_d;
    logic [A-1:0] i_q, i_d;
    logic [W-1:0] hold_q, hold_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         we_q, we_d;
    logic [A-1:0] addr_q, addr_d;
    logic [W-1:0] din_q, din_d;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        i_d     = i_q;
        hold_d  = hold_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mode_d = Mode;
                    src_d  = SrcAddr;
                    dst_d  = DstAddr;
                    len_d  = Length;
                    fill_d = FillValue;
                    i_d    = '0;
                    if (Length == '0) begin
                        state_d = S_DONE;
                    end else if (Mode) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                // Memory latched the address on the falling edge; data is valid now.
                hold_d  = mem.MemDataOut;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                i_d = i_q + ONE;
                if (i_d == len_q) begin
                    state_d = S_DONE;
                end else if (mode_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Port outputs are registered from the next state so they line up with it.
        we_d   = 1'b0;
        addr_d = '0;
        din_d  = '0;
        busy_d = 1'b0;
        done_d = (state_d == S_DONE);
        case (state_d)
            S_READ: begin
                busy_d = 1'b1;
                addr_d = src_d + i_d;
            end
            S_WRITE: begin
                busy_d = 1'b1;
                we_d   = 1'b1;
                addr_d = dst_d + i_d;
                din_d  = mode_d ? fill_d : hold_d;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            i_q     <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            i_q     <= i_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    // The memory writes on the falling edge, so a reset raised mid-WRITE must
    // suppress the enable combinationally to keep that write from committing.
    assign mem.MemWriteEn = we_q & ~Reset;
    assign mem.MemDataIn  = din_q;
    assign mem.MemAddress = addr_q;
    assign Busy           = busy_q;
    assign Done           = done_q;
endmodule

// File: tb/tb_dma_copy.sv
// tb/tb_dma_copy.sv - directed self-checking bench for dma_copy
module tb_dma_copy;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Mode;
    logic [7:0] SrcAddr;
    logic [7:0] DstAddr;
    logic [7:0] Length;
    logic [7:0] FillValue;
    logic       Busy;
    logic       Done;

    always #5 Clk = ~Clk;

    dma_copy_if #(.W(8), .A(8)) mem_if ();

    dma_copy #(.W(8), .A(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Mode      (Mode),
        .SrcAddr   (SrcAddr),
        .DstAddr   (DstAddr),
        .Length    (Length),
        .FillValue (FillValue),
        .Busy      (Busy),
        .Done      (Done),
        .mem       (mem_if)
    );

    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];
    logic [7:0] rdata;
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;

    always @(negedge Clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_if.MemWriteEn === 1'b1) begin
            mem[mem_if.MemAddress] <= mem_if.MemDataIn;
        end
        rdata <= mem[mem_if.MemAddress];
    end
    assign mem_if.MemDataOut = rdata;

    int checks   = 0;
    int failures = 0;

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge Clk);
        #1;
        ld_en      = 1'b0;
        exp_mem[a] = d;
    endtask

    function automatic int count_mem_diffs();
        int n = 0;
        for (int k = 0; k < 256; k++) begin
            if (mem[k] !== exp_mem[k]) n++;
        end
        return n;
    endfunction

    // Returns at #1 after the edge that sampled Start, i.e. inside cycle 1.
    task automatic start_xfer(input logic m, input logic [7:0] s, input logic [7:0] d,
                              input logic [7:0] l, input logic [7:0] f);
        @(posedge Clk);
        #1;
        Mode      = m;
        SrcAddr   = s;
        DstAddr   = d;
        Length    = l;
        FillValue = f;
        Start     = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic run_cycles(input int n, output int busy_n, output int done_n,
                              output int done_cyc, output int we_n, output int first_busy);
        busy_n = 0; done_n = 0; done_cyc = 0; we_n = 0; first_busy = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge Clk);
            if (Busy === 1'b1) begin
                busy_n++;
                if (first_busy == 0) first_busy = c;
            end
            if (Done === 1'b1) begin
                done_n++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (mem_if.MemWriteEn === 1'b1) we_n++;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        int b, dn, dc, w, fb, diffs;
        Reset = 1'b1;
        Start = 1'b1; Mode = 1'b1; DstAddr = 8'hC0; Length = 8'd2; FillValue = 8'h99;
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({Busy, Done, mem_if.MemWriteEn} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: busy/done/we=%b required 000", {Busy, Done, mem_if.MemWriteEn});
        end
        checks++;
        if ({mem_if.MemAddress, mem_if.MemDataIn} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_bus: addr/din=%h required 0000", {mem_if.MemAddress, mem_if.MemDataIn});
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        Start = 1'b0;
        run_cycles(5, b, dn, dc, w, fb);
        checks++;
        if (b !== 0 || dn !== 0 || w !== 0) begin
            failures++;
            $display("FAIL reset_start_dropped: busy=%0d done=%0d we=%0d required 0 0 0", b, dn, w);
        end
        diffs = count_mem_diffs();
        checks++;
        if (diffs !== 0) begin
            failures++;
            $display("FAIL reset_mem: %0d words differ required 0", diffs);
        end
    endtask

    task automatic test_copy_basic();
        int b, dn, dc, w, fb, diffs;
        load(8'h10, 8'hA1); load(8'h11, 8'hB2); load(8'h12, 8'hC3); load(8'h13, 8'hD4);
        start_xfer(1'b0, 8'h10, 8'h40, 8'd4, 8'h00);
        run_cycles(14, b, dn, dc, w, fb);
        exp_mem[8'h40] = 8'hA1; exp_mem[8'h41] = 8'hB2;
        exp_mem[8'h42] = 8'hC3; exp_mem[8'h43] = 8'hD4;
        checks++;
        if (b !== 8 || fb !== 1) begin
            failures++;
            $display("FAIL copy_busy: busy=%0d first=%0d required 8 1", b, fb);
        end
        // Done in cycle 9 after the sampling edge = cycle 10 counting the Start cycle.
        checks++;
        if (dn !== 1 || dc !== 9) begin
            failures++;
            $display("FAIL copy_done: count=%0d cycle=%0d required 1 9", dn, dc);
        end
        checks++;
        if (w !== 4) begin
            failures++;
            $display("FAIL copy_we: writes=%0d required 4", w);
        end
        diffs = count_mem_diffs();
        checks++;
        if (diffs !== 0 || mem[8'h43] !== 8'hD4) begin
            failures++;
            $display("FAIL copy_mem: diffs=%0d mem43=%h required 0 d4", diffs, mem[8'h43]);
        end
    endtask

    task automatic test_fill_wrap();
        int b, dn, dc, w, fb, diffs;
        start_xfer(1'b1, 8'h00, 8'hFE, 8'd4, 8'h5A);
        run_cycles(8, b, dn, dc, w, fb);
        exp_mem[8'hFE] = 8'h5A; exp_mem[8'hFF] = 8'h5A;
        exp_mem[8'h00] = 8'h5A; exp_mem[8'h01] = 8'h5A;
        checks++;
        if (b !== 4 || dn !== 1 || dc !== 5) begin
            failures++;
            $display("FAIL fill_timing: busy=%0d done=%0d at %0d required 4 1 5", b, dn, dc);
        end
        checks++;
        if (mem[8'h01] !== 8'h5A || mem[8'h02] !== 8'h11) begin
            failures++;
            $display("FAIL fill_wrap_edge: mem01=%h mem02=%h required 5a 11", mem[8'h01], mem[8'h02]);
        end
        diffs = count_mem_diffs();
        checks++;
        if (diffs !== 0) begin
            failures++;
            $display("FAIL fill_mem: %0d words differ required 0", diffs);
        end
    endtask

    task automatic test_zero_length();
        int b, dn, dc, w, fb, diffs;
        start_xfer(1'b0, 8'h10, 8'h30, 8'd0, 8'h00);
        run_cycles(4, b, dn, dc, w, fb);
        checks++;
        if (b !== 0 || w !== 0) begin
            failures++;
            $display("FAIL zero_len_quiet: busy=%0d we=%0d required 0 0", b, w);
        end
        checks++;
        if (dn !== 1 || dc !== 1) begin
            failures++;
            $display("FAIL zero_len_done: count=%0d cycle=%0d required 1 1", dn, dc);
        end
        diffs = count_mem_diffs();
        checks++;
        if (diffs !== 0) begin
            failures++;
            $display("FAIL zero_len_mem: %0d words differ required 0", diffs);
        end
    endtask

    task automatic test_overlap();
        int b, dn, dc, w, fb, diffs;
        load(8'h20, 8'h11); load(8'h21, 8'h22); load(8'h22, 8'h33);
        start_xfer(1'b0, 8'h20, 8'h21, 8'd2, 8'h00);
        run_cycles(8, b, dn, dc, w, fb);
        exp_mem[8'h21] = 8'h11; exp_mem[8'h22] = 8'h11;
        checks++;
        if (mem[8'h21] !== 8'h11 || mem[8'h22] !== 8'h11) begin
            failures++;
            $display("FAIL overlap_data: mem21=%h mem22=%h required 11 11", mem[8'h21], mem[8'h22]);
        end
        diffs = count_mem_diffs();
        checks++;
        if (diffs !== 0 || b !== 4 || dc !== 5) begin
            failures++;
            $display("FAIL overlap_misc: diffs=%0d busy=%0d done_cyc=%0d required 0 4 5", diffs, b, dc);
        end
    endtask

    task automatic test_ignored_start();
        int b1, d1, dc1, w1, fb1, b2, d2, dc2, w2, fb2, diffs;
        load(8'h80, 8'h31); load(8'h81, 8'h32); load(8'h82, 8'h33);
        start_xfer(1'b0, 8'h80, 8'h88, 8'd3, 8'h00);
        Start = 1'b1; Mode = 1'b1; SrcAddr = 8'h00; DstAddr = 8'h90; Length = 8'd5; FillValue = 8'hFF;
        run_cycles(3, b1, d1, dc1, w1, fb1);
        Start = 1'b0;
        run_cycles(9, b2, d2, dc2, w2, fb2);
        exp_mem[8'h88] = 8'h31; exp_mem[8'h89] = 8'h32; exp_mem[8'h8A] = 8'h33;
        checks++;
        if (b1 + b2 !== 6 || d1 + d2 !== 1 || w1 + w2 !== 3) begin
            failures++;
            $display("FAIL ignored_start_counts: busy=%0d done=%0d we=%0d required 6 1 3",
                     b1 + b2, d1 + d2, w1 + w2);
        end
        diffs = count_mem_diffs();
        checks++;
        if (diffs !== 0) begin
            failures++;
            $display("FAIL ignored_start_mem: %0d words differ required 0", diffs);
        end
    endtask

    task automatic test_reset_mid_write();
        int b, dn, dc, w, fb, diffs;
        load(8'h50, 8'h01); load(8'h51, 8'h02); load(8'h52, 8'h03); load(8'h53, 8'h04);
        start_xfer(1'b0, 8'h50, 8'h60, 8'd4, 8'h00);
        repeat (3) begin
            @(posedge Clk);
            #1;
        end
        Reset = 1'b1;
        @(negedge Clk);
        checks++;
        if (mem_if.MemWriteEn !== 1'b0 || Busy !== 1'b1 || mem_if.MemAddress !== 8'h61) begin
            failures++;
            $display("FAIL rst_mid_we: we=%b busy=%b addr=%h required 0 1 61",
                     mem_if.MemWriteEn, Busy, mem_if.MemAddress);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || mem_if.MemAddress !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_idle: busy=%b done=%b addr=%h required 0 0 00",
                     Busy, Done, mem_if.MemAddress);
        end
        run_cycles(5, b, dn, dc, w, fb);
        exp_mem[8'h60] = 8'h01;
        diffs = count_mem_diffs();
        checks++;
        if (dn !== 0 || b !== 0 || diffs !== 0) begin
            failures++;
            $display("FAIL rst_mid_after: done=%0d busy=%0d diffs=%0d required 0 0 0", dn, b, diffs);
        end
        start_xfer(1'b0, 8'h52, 8'h64, 8'd1, 8'h00);
        run_cycles(5, b, dn, dc, w, fb);
        exp_mem[8'h64] = 8'h03;
        diffs = count_mem_diffs();
        checks++;
        if (b !== 2 || dc !== 3 || diffs !== 0) begin
            failures++;
            $display("FAIL rst_mid_restart: busy=%0d done_cyc=%0d diffs=%0d required 2 3 0", b, dc, diffs);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:1] busy_v, done_v;
        int diffs;
        busy_v = '0;
        done_v = '0;
        start_xfer(1'b1, 8'h00, 8'hA0, 8'd1, 8'h77);
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) begin
                DstAddr = 8'hA1; FillValue = 8'h78;
            end
            // Held through DONE (ignored) and the first IDLE cycle (accepted).
            Start = (c == 2 || c == 3);
            @(negedge Clk);
            busy_v[c] = (Busy === 1'b1);
            done_v[c] = (Done === 1'b1);
            @(posedge Clk);
            #1;
        end
        Start = 1'b0;
        exp_mem[8'hA0] = 8'h77; exp_mem[8'hA1] = 8'h78;
        checks++;
        if (busy_v !== 8'b0000_1001 || done_v !== 8'b0001_0010) begin
            failures++;
            $display("FAIL b2b_timing: busy=%b done=%b required 00001001 00010010", busy_v, done_v);
        end
        diffs = count_mem_diffs();
        checks++;
        if (diffs !== 0) begin
            failures++;
            $display("FAIL b2b_mem: %0d words differ required 0", diffs);
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Mode = 1'b0;
        SrcAddr = '0; DstAddr = '0; Length = '0; FillValue = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        for (int k = 0; k < 256; k++) begin
            load(8'(k), 8'(k * 7 + 3));
        end
        test_reset();
        test_copy_basic();
        test_fill_wrap();
        test_zero_length();
        test_overlap();
        test_ignored_start();
        test_reset_mid_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
